// File: rtl/step_counter_pkg.sv
// Shared types and elaboration-time helpers for the arithmetic-progression counter.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package step_counter_pkg;

    // Boundary behaviour selector; the reserved encoding behaves as wrap.
    typedef enum logic [1:0] {
        MODE_WRAP = 2'b00,
        MODE_SAT  = 2'b01,
        MODE_PING = 2'b10,
        MODE_RSVD = 2'b11
    } mode_t;

    // Largest sequence member that still fits in 'width' bits.
    // The subtraction is done in 64 bits so widths up to 31 do not overflow.
    function automatic int calc_max(input int width, input int step, input int base);
        longint span;
        span = (longint'(1) << width) - 64'sd1 - longint'(base);
        return int'(longint'(base) + longint'(step) * (span / longint'(step)));
    endfunction

    // A value is legal when it lies on the progression between MIN and MAX.
    function automatic logic is_legal(input int v, input int base, input int step,
                                      input int max_v);
        return (v >= base) && (v <= max_v) && (((v - base) % step) == 0);
    endfunction

endpackage

// File: rtl/step_counter_next.sv
// Next-value logic for the progression counter: step, boundary detect, boundary policy.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is registered.
module step_counter_next
    import step_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEP  = 2,
    parameter int BASE  = 1
) (
    input  logic [WIDTH-1:0] cur_out,
    input  logic             d,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_out,
    output logic             next_dir,
    output logic             hit_boundary
);

    localparam int               MAX_I  = calc_max(WIDTH, STEP, BASE);
    localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(BASE);
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_I);
    // A single-member sequence can never step; every enabled cycle is a boundary.
    localparam bit               DEGEN  = (MAX_I == BASE);
    // Ping-pong rebound targets; only meaningful when the sequence has >= 2 members.
    localparam logic [WIDTH-1:0] MAX_DN = WIDTH'(MAX_I - STEP);
    localparam logic [WIDTH-1:0] MIN_UP = WIDTH'(BASE + STEP);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);

    // One extra bit so the step itself never wraps before the boundary check.
    logic [WIDTH:0] up_sum;
    logic [WIDTH:0] dn_diff;
    logic           at_edge;
    logic           unused_carry;

    assign up_sum       = {1'b0, cur_out} + STEP_X;
    assign dn_diff      = {1'b0, cur_out} - STEP_X;
    // Legal values never carry past MAX or borrow below MIN, so the top bits are dead.
    assign unused_carry = up_sum[WIDTH] ^ dn_diff[WIDTH];
    assign at_edge      = d ? (cur_out == MAX_V) : (cur_out == MIN_V);

    // Select the next count and direction according to the boundary policy.
    always_comb begin
        next_out     = cur_out;
        next_dir     = d;
        hit_boundary = 1'b0;
        if (DEGEN) begin
            next_out     = MIN_V;
            hit_boundary = 1'b1;
        end else if (at_edge) begin
            hit_boundary = 1'b1;
            case (mode_t'(mode))
                MODE_SAT: begin
                    next_out = cur_out;
                end
                MODE_PING: begin
                    next_out = d ? MAX_DN : MIN_UP;
                    next_dir = ~d;
                end
                default: begin
                    next_out = d ? MIN_V : MAX_V;
                end
            endcase
        end else begin
            next_out = d ? up_sum[WIDTH-1:0] : dn_diff[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/step_updown_counter.sv
// Up/down counter stepping BASE, BASE+STEP, ... MAX with wrap/saturate/ping-pong ends.
// Latency: one cycle from inputs to out/tc/load_err; no backpressure, en simply holds.
// Optional STEP_COUNTER_WRAP_COUNT_EN adds an 8-bit saturating terminal-count tally.
module step_updown_counter
    import step_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEP  = 2,
    parameter int BASE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             Y,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             dir_q,
    output logic             tc,
`ifdef STEP_COUNTER_WRAP_COUNT_EN
    output logic [7:0]       wrap_cnt,
`endif
    output logic             load_err
);

    localparam int               MAX_I = calc_max(WIDTH, STEP, BASE);
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(BASE);

    logic             d;
    logic             load_ok;
    logic [WIDTH-1:0] next_out;
    logic             next_dir;
    logic             hit_boundary;

    // Ping-pong follows its own registered direction; the other modes obey Y directly.
    assign d       = (mode == MODE_PING) ? dir_q : Y;
    assign load_ok = is_legal(int'(32'(load_val)), BASE, STEP, MAX_I);

    step_counter_next #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .BASE  (BASE)
    ) u_next (
        .cur_out      (out),
        .d            (d),
        .mode         (mode),
        .next_out     (next_out),
        .next_dir     (next_dir),
        .hit_boundary (hit_boundary)
    );

    // Count state with reset > load > enable > hold priority; tc/load_err are one-cycle pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            out      <= MIN_V;
            dir_q    <= 1'b1;
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else if (load) begin
            out      <= load_ok ? load_val : MIN_V;
            dir_q    <= Y;
            tc       <= 1'b0;
            load_err <= ~load_ok;
        end else if (en) begin
            out      <= next_out;
            dir_q    <= next_dir;
            tc       <= hit_boundary;
            load_err <= 1'b0;
        end else begin
            tc       <= 1'b0;
            load_err <= 1'b0;
        end
    end

`ifdef STEP_COUNTER_WRAP_COUNT_EN
    // Tally terminal counts in the same edge that raises tc, so wrap_cnt and tc line up.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            wrap_cnt <= 8'd0;
        end else if (en && hit_boundary && (wrap_cnt != 8'hFF)) begin
            wrap_cnt <= wrap_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_step_updown_counter.sv
// Self-checking bench: vector table, directed boundary sequences, random vs index model.
// Two instances: defaults (4/2/1) and a 6-bit stride-3 base-2 counter.
// Builds with or without STEP_COUNTER_WRAP_COUNT_EN.
module tb_step_updown_counter;

    logic       clk;
    logic       rst_a, en_a, y_a, ld_a;
    logic [1:0] md_a;
    logic [3:0] lv_a;
    logic [3:0] out_a;
    logic       dir_a, tc_a, err_a;
    logic       rst_b, en_b, y_b, ld_b;
    logic [1:0] md_b;
    logic [5:0] lv_b;
    logic [5:0] out_b;
    logic       dir_b, tc_b, err_b;
`ifdef STEP_COUNTER_WRAP_COUNT_EN
    logic [7:0] wc_a, wc_b;
`endif

    int total = 0;
    int bad   = 0;

    step_updown_counter u_dut_a (
        .clk(clk), .reset(rst_a), .en(en_a), .Y(y_a), .mode(md_a),
        .load(ld_a), .load_val(lv_a), .out(out_a), .dir_q(dir_a), .tc(tc_a),
`ifdef STEP_COUNTER_WRAP_COUNT_EN
        .wrap_cnt(wc_a),
`endif
        .load_err(err_a)
    );

    step_updown_counter #(.WIDTH(6), .STEP(3), .BASE(2)) u_dut_b (
        .clk(clk), .reset(rst_b), .en(en_b), .Y(y_b), .mode(md_b),
        .load(ld_b), .load_val(lv_b), .out(out_b), .dir_q(dir_b), .tc(tc_b),
`ifdef STEP_COUNTER_WRAP_COUNT_EN
        .wrap_cnt(wc_b),
`endif
        .load_err(err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: the count is tracked as a position in the list of sequence members.
    typedef struct {
        int out;
        bit dir;
        bit tc;
        bit err;
        int wc;
    } mstate_t;

    mstate_t sa, sb;

    function automatic mstate_t ref_next(mstate_t s, int w, int stp, int base,
                                         bit rst, bit ld, int lv, bit en, bit y, int md);
        mstate_t r;
        int n, mx, idx;
        bit dd;
        r   = s;
        n   = ((1 << w) - 1 - base) / stp + 1;
        mx  = base + (n - 1) * stp;
        r.tc  = 1'b0;
        r.err = 1'b0;
        if (rst) begin
            r.out = base; r.dir = 1'b1; r.wc = 0;
            return r;
        end
        if (ld) begin
            if (lv >= base && lv <= mx && ((lv - base) % stp) == 0) r.out = lv;
            else begin
                r.out = base; r.err = 1'b1;
            end
            r.dir = y; r.wc = 0;
            return r;
        end
        if (!en) return r;
        dd    = (md == 2) ? s.dir : y;
        idx   = (s.out - base) / stp;
        r.dir = dd;
        if (n == 1) begin
            r.tc = 1'b1;
        end else if (dd && idx == n - 1) begin
            r.tc = 1'b1;
            if (md == 2) begin idx = n - 2; r.dir = 1'b0; end
            else if (md != 1) idx = 0;
        end else if (!dd && idx == 0) begin
            r.tc = 1'b1;
            if (md == 2) begin idx = 1; r.dir = 1'b1; end
            else if (md != 1) idx = n - 1;
        end else begin
            idx = dd ? idx + 1 : idx - 1;
        end
        r.out = base + idx * stp;
        if (r.tc && r.wc < 255) r.wc = r.wc + 1;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Advance one clock; both models consume the inputs present at the edge.
    task automatic tick();
        sa = ref_next(sa, 4, 2, 1, rst_a, ld_a, int'(lv_a), en_a, y_a, int'(md_a));
        sb = ref_next(sb, 6, 3, 2, rst_b, ld_b, int'(lv_b), en_b, y_b, int'(md_b));
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input bit rst, input bit ld, input int lv, input bit en,
                           input bit y, input int md);
        rst_a = rst; ld_a = ld; lv_a = 4'(lv); en_a = en; y_a = y; md_a = 2'(md);
    endtask

    task automatic expect_a(input string nm, input int o, input bit dr, input bit t, input bit e);
        chk({nm, "_out"}, 32'(out_a), 32'(o));
        chk({nm, "_dir"}, 32'(dir_a), 32'(dr));
        chk({nm, "_tc"},  32'(tc_a),  32'(t));
        chk({nm, "_err"}, 32'(err_a), 32'(e));
    endtask

    task automatic check_models(input int cyc);
        chk($sformatf("rnd%0d_a_out", cyc), 32'(out_a), 32'(sa.out));
        chk($sformatf("rnd%0d_a_dir", cyc), 32'(dir_a), 32'(sa.dir));
        chk($sformatf("rnd%0d_a_tc",  cyc), 32'(tc_a),  32'(sa.tc));
        chk($sformatf("rnd%0d_a_err", cyc), 32'(err_a), 32'(sa.err));
        chk($sformatf("rnd%0d_b_out", cyc), 32'(out_b), 32'(sb.out));
        chk($sformatf("rnd%0d_b_dir", cyc), 32'(dir_b), 32'(sb.dir));
        chk($sformatf("rnd%0d_b_tc",  cyc), 32'(tc_b),  32'(sb.tc));
        chk($sformatf("rnd%0d_b_err", cyc), 32'(err_b), 32'(sb.err));
`ifdef STEP_COUNTER_WRAP_COUNT_EN
        chk($sformatf("rnd%0d_a_wc", cyc), 32'(wc_a), 32'(sa.wc));
        chk($sformatf("rnd%0d_b_wc", cyc), 32'(wc_b), 32'(sb.wc));
`endif
    endtask

    typedef struct {
        bit rst; bit ld; int lv; bit en; bit y; int md;
        int e_out; bit e_dir; bit e_tc; bit e_err;
    } vec_t;

    vec_t tv[$];

    task automatic add(input bit rst, input bit ld, input int lv, input bit en, input bit y,
                       input int md, input int o, input bit dr, input bit t, input bit e);
        vec_t v;
        v.rst = rst; v.ld = ld; v.lv = lv; v.en = en; v.y = y; v.md = md;
        v.e_out = o; v.e_dir = dr; v.e_tc = t; v.e_err = e;
        tv.push_back(v);
    endtask

    initial begin
        sa = '{out: 0, dir: 1'b0, tc: 1'b0, err: 1'b0, wc: 0};
        sb = sa;
        drive_a(1, 0, 0, 0, 1, 0);
        rst_b = 1'b1; ld_b = 1'b0; lv_b = '0; en_b = 1'b0; y_b = 1'b1; md_b = 2'd0;

        // Wrap upward through 1..15 and back to 1.
        add(1, 0, 0, 0, 1, 0,   1, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0,   3, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0,   5, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0,   7, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0,   9, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0,  11, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0,  13, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0,  15, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0,   1, 1, 1, 0);
        add(0, 0, 0, 1, 1, 0,   3, 1, 0, 0);
        // Wrap downward from MIN, then hold with en low.
        add(0, 1, 1, 0, 0, 0,   1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0,  15, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0,  13, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,  13, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,  13, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,  13, 0, 0, 0);
        // Illegal loads (off-grid, zero below MIN), legal load, reset beating load and en.
        add(0, 1, 6, 0, 1, 0,   1, 1, 0, 1);
        add(0, 0, 0, 0, 1, 0,   1, 1, 0, 0);
        add(0, 1, 9, 0, 1, 0,   9, 1, 0, 0);
        add(0, 1, 0, 1, 0, 0,   1, 0, 0, 1);
        add(0, 1, 9, 1, 0, 0,   9, 0, 0, 0);
        add(1, 1, 9, 1, 0, 0,   1, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0,   3, 1, 0, 0);
        add(1, 0, 0, 1, 1, 0,   1, 1, 0, 0);

        for (int i = 0; i < tv.size(); i++) begin
            drive_a(tv[i].rst, tv[i].ld, tv[i].lv, tv[i].en, tv[i].y, tv[i].md);
            tick();
            rst_b = 1'b0;
            expect_a($sformatf("vec%0d", i), tv[i].e_out, tv[i].e_dir, tv[i].e_tc, tv[i].e_err);
        end

        // Saturate at MAX, then walk down and saturate at MIN.
        drive_a(0, 1, 13, 0, 1, 1); tick(); expect_a("sat_load", 13, 1, 0, 0);
        drive_a(0, 0, 0, 1, 1, 1);  tick(); expect_a("sat_up15", 15, 1, 0, 0);
        tick(); expect_a("sat_hold1", 15, 1, 1, 0);
        tick(); expect_a("sat_hold2", 15, 1, 1, 0);
        drive_a(0, 0, 0, 1, 0, 1);
        for (int v = 13; v >= 1; v -= 2) begin
            tick(); expect_a($sformatf("sat_dn%0d", v), v, 0, 0, 0);
        end
        tick(); expect_a("sat_min", 1, 0, 1, 0);

        // Ping-pong: direction comes from dir_q and Y is ignored.
        drive_a(0, 1, 13, 0, 1, 2); tick(); expect_a("pp_load", 13, 1, 0, 0);
        drive_a(0, 0, 0, 1, 0, 2);  tick(); expect_a("pp_15", 15, 1, 0, 0);
        tick(); expect_a("pp_bounce_top", 13, 0, 1, 0);
        for (int v = 11; v >= 1; v -= 2) begin
            tick(); expect_a($sformatf("pp_dn%0d", v), v, 0, 0, 0);
        end
        tick(); expect_a("pp_bounce_bot", 3, 1, 1, 0);
        tick(); expect_a("pp_5", 5, 1, 0, 0);

        // Reserved mode acts as wrap.
        drive_a(0, 1, 15, 0, 1, 3); tick(); expect_a("rsv_load", 15, 1, 0, 0);
        drive_a(0, 0, 0, 1, 1, 3);  tick(); expect_a("rsv_wrap", 1, 1, 1, 0);

        // Wider instance: 59 -> 62 -> wrap to 2.
        drive_a(0, 0, 0, 0, 1, 0);
        ld_b = 1'b1; lv_b = 6'd59; en_b = 1'b0; y_b = 1'b1; md_b = 2'd0;
        tick(); chk("b_load", 32'(out_b), 32'd59);
`ifdef STEP_COUNTER_WRAP_COUNT_EN
        chk("b_wc0", 32'(wc_b), 32'd0);
`endif
        ld_b = 1'b0; en_b = 1'b1;
        tick(); chk("b_62", 32'(out_b), 32'd62); chk("b_62_tc", 32'(tc_b), 32'd0);
        tick(); chk("b_wrap", 32'(out_b), 32'd2); chk("b_wrap_tc", 32'(tc_b), 32'd1);
`ifdef STEP_COUNTER_WRAP_COUNT_EN
        chk("b_wc1", 32'(wc_b), 32'd1);
        // Park at MAX in saturate mode long enough to pin the tally at 255.
        ld_b = 1'b1; lv_b = 6'd62; tick(); ld_b = 1'b0; md_b = 2'd1;
        for (int i = 0; i < 260; i++) tick();
        chk("b_wc_sat", 32'(wc_b), 32'd255);
`endif

        // Random traffic on both instances against the position-based model.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 15) == 0) md_a = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) md_b = 2'($urandom_range(0, 3));
            rst_a = ($urandom_range(0, 59) == 0);
            ld_a  = ($urandom_range(0, 9) == 0);
            lv_a  = 4'($urandom_range(0, 15));
            en_a  = ($urandom_range(0, 3) != 0);
            y_a   = 1'($urandom_range(0, 1));
            rst_b = ($urandom_range(0, 59) == 0);
            ld_b  = ($urandom_range(0, 9) == 0);
            lv_b  = 6'($urandom_range(0, 63));
            en_b  = ($urandom_range(0, 3) != 0);
            y_b   = 1'($urandom_range(0, 1));
            tick();
            check_models(c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
